uart_cmd_parser: RTL
====================

// Module: uart_cmd_parser
// PURPOSE
//  Consumes the byte stream from the UART receiver (rx_data/rx_valid) and parses ASCII command lines.
//  Successful commands load the LED register and the 8-digit hex display value.
//  Each line produces a one-byte status response, which the block transmits through the UART
//  transmitter handshake (tx_data/tx_send/tx_busy).
//  Sits between the uart instance and the LD / EightSevenSegmentDisplays inputs in top.
// PARAMETERS
//  CLOCK_FREQ   100_000_000  clock frequency in Hz
//  TIMEOUT_MS   10           max gap between bytes inside a line before abort
//  ACK_CHAR     8'h4B ('K')  response for an accepted command
//  NAK_CHAR     8'h45 ('E')  response for a malformed command
//  TMO_CHAR     8'h54 ('T')  response for an inter-byte timeout
// PORTS
//  clock        in   1   system clock
//  reset_n      in   1   asynchronous, active-low reset
//  rx_data      in   8   received byte, valid while rx_valid=1
//  rx_valid     in   1   one-cycle strobe per received byte
//  tx_data      out  8   response byte to UART transmitter
//  tx_send      out  1   one-cycle request to transmit tx_data
//  tx_busy      in   1   transmitter busy
//  led_value    out  16  LED register
//  hex_digits   out  32  display nibbles; [31:28]=HEX7 .. [3:0]=HEX0
//  led_load     out  1   one-cycle pulse when led_value updates
//  hex_load     out  1   one-cycle pulse when hex_digits updates
//  overrun_cnt  out  8   count of responses dropped, saturating at 255
// BEHAVIOUR
//  Reset: all outputs are 0, parser is in IDLE, TX FSM is in T_IDLE, response buffer is empty.
//  Line format: cmd char, then hex digits, then a terminator (CR 8'h0D or LF 8'h0A).
//   'L' takes exactly 4 digits -> led_value.
//   'H' takes exactly 8 digits -> hex_digits.
//   Command char and hex digits are case-insensitive (0-9, A-F, a-f).
//   The first digit received is the most significant nibble.
//  Parser FSM:
//   IDLE:    on a terminator, stay in IDLE with no response (empty line / CRLF pair).
//            On L/l or H/h, latch cmd, clear shift reg and digit count, go to COLLECT.
//            On any other byte, go to FLUSH.
//   COLLECT: on a hex digit with count < N, shift nibble in and increment count.
//            On a hex digit with count == N, or on a non-hex non-terminator byte, go to FLUSH.
//            On a terminator with count == N, load the target, queue ACK_CHAR, go to IDLE.
//            On a terminator with count != N, queue NAK_CHAR, go to IDLE; no output changes.
//   FLUSH:   discard bytes; on a terminator, queue NAK_CHAR and go to IDLE.
//  Timeout: a counter of CLOCK_FREQ/1000*TIMEOUT_MS cycles runs in COLLECT/FLUSH and restarts on every rx_valid.
//   On expiry, queue TMO_CHAR and go to IDLE; no output load.
//  Load latency: led_value/hex_digits and the matching *_load pulse are registered.
//   They appear on the cycle after the terminator's rx_valid.
//  Partial lines never modify outputs. Narrower shift-reg content does not leak: exact count is required.
//  Response buffer (1 entry):
//   Queueing while the buffer is full drops the new byte and increments overrun_cnt (saturating).
//   Queue and dequeue in the same cycle: the dequeue happens first and the new byte is accepted.
//  TX FSM:
//   T_IDLE: when the buffer is full and tx_busy=0, drive tx_data and pulse tx_send for 1 cycle,
//           empty the buffer, go to T_GUARD.
//   T_GUARD: wait one cycle.
//   T_BUSY: wait for tx_busy=0, then go to T_IDLE.
//   tx_data holds its value from the pulse until the next pulse.
//  rx_valid is accepted every cycle; the parser never stalls, and rx is independent of TX state.
//  reset_n low mid-line or mid-send: immediate return to reset values; the pending response is lost.
// TESTING
//  "L00FF\n" -> led_value=16'h00FF and led_load pulse 1 cycle after the '\n' strobe; tx_data=8'h4B with one tx_send.
//  "hdeadBEEF\r\n" -> hex_digits=32'hDEADBEEF; exactly one 'K' (the LF in IDLE is silent).
//  "L12\n", then "LZZZZ\n", then "X1\n" -> three 'E' responses; led_value is unchanged from its prior value.
//  "L12" then silence > TIMEOUT_MS -> 'T' sent; the next "L0001\n" is accepted normally.
//  tx_busy held high while 3 lines complete -> first response buffered, two dropped;
//   overrun_cnt=2 and one 'K' is sent after tx_busy falls.
//  reset_n asserted mid "H1234" -> all outputs 0; "H0000000A\n" after release gives hex_digits=32'hA.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses "L<4 hex>" / "H<8 hex>" command lines from the UART
// receiver, loads the LED and hex display registers, and answers each line
// with a single status byte through a one-entry buffer and the UART transmitter.
module uart_cmd_parser #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter logic [7:0]  ACK_CHAR   = 8'h4B,
  parameter logic [7:0]  NAK_CHAR   = 8'h45,
  parameter logic [7:0]  TMO_CHAR   = 8'h54
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic [15:0] led_value,
  output logic [31:0] hex_digits,
  output logic        led_load,
  output logic        hex_load,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned TMO_CYCLES = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned TW         = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_GUARD, T_BUSY} t_state_t;

  p_state_t       p_state;
  t_state_t       t_state;
  logic           cmd_is_h;
  logic [31:0]    shreg;
  logic [3:0]     dig_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           buf_full;
  logic [7:0]     buf_data;

  logic           rx_is_term, rx_is_hex, rx_is_l, rx_is_h;
  logic [3:0]     rx_nib;
  logic [3:0]     need_n;
  logic           timeout_hit;
  logic           q_valid;
  logic [7:0]     q_char;
  logic           do_load;
  logic           deq;

  // Classify the incoming byte: terminator, command letter, hex digit value.
  always_comb begin
    rx_is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    rx_is_l    = (rx_data == 8'h4C) || (rx_data == 8'h6C);
    rx_is_h    = (rx_data == 8'h48) || (rx_data == 8'h68);
    rx_is_hex  = 1'b1;
    rx_nib     = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      rx_nib = rx_data[3:0];
    else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66))
      rx_nib = rx_data[3:0] + 4'd9;
    else
      rx_is_hex = 1'b0;
  end

  // Line outcome for this cycle: response byte to queue and whether to load a target.
  always_comb begin
    need_n      = cmd_is_h ? 4'd8 : 4'd4;
    timeout_hit = (p_state != IDLE) && !rx_valid && (tmo_cnt == TW'(TMO_CYCLES - 1));
    q_valid     = 1'b0;
    q_char      = 8'h00;
    do_load     = 1'b0;
    if (timeout_hit) begin
      q_valid = 1'b1;
      q_char  = TMO_CHAR;
    end else if (rx_valid && rx_is_term) begin
      if (p_state == COLLECT) begin
        q_valid = 1'b1;
        do_load = (dig_cnt == need_n);
        q_char  = do_load ? ACK_CHAR : NAK_CHAR;
      end else if (p_state == FLUSH) begin
        q_valid = 1'b1;
        q_char  = NAK_CHAR;
      end
    end
  end

  assign deq = (t_state == T_IDLE) && buf_full && !tx_busy;

  // Parser FSM with inter-byte timeout and registered target loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_state    <= IDLE;
      cmd_is_h   <= 1'b0;
      shreg      <= 32'h0;
      dig_cnt    <= 4'd0;
      tmo_cnt    <= '0;
      led_value  <= 16'h0;
      hex_digits <= 32'h0;
      led_load   <= 1'b0;
      hex_load   <= 1'b0;
    end else begin
      led_load <= 1'b0;
      hex_load <= 1'b0;
      if (p_state == IDLE || rx_valid) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + TW'(1);

      if (timeout_hit) begin
        p_state <= IDLE;
      end else if (rx_valid) begin
        case (p_state)
          IDLE: begin
            if (rx_is_term) begin
              p_state <= IDLE;
            end else if (rx_is_l || rx_is_h) begin
              cmd_is_h <= rx_is_h;
              shreg    <= 32'h0;
              dig_cnt  <= 4'd0;
              p_state  <= COLLECT;
            end else begin
              p_state <= FLUSH;
            end
          end
          COLLECT: begin
            if (rx_is_term) begin
              p_state <= IDLE;
            end else if (rx_is_hex && dig_cnt < need_n) begin
              shreg   <= {shreg[27:0], rx_nib};
              dig_cnt <= dig_cnt + 4'd1;
            end else begin
              p_state <= FLUSH;
            end
          end
          FLUSH: begin
            if (rx_is_term) p_state <= IDLE;
          end
          default: p_state <= IDLE;
        endcase
      end

      if (do_load) begin
        if (cmd_is_h) begin
          hex_digits <= shreg;
          hex_load   <= 1'b1;
        end else begin
          led_value <= shreg[15:0];
          led_load  <= 1'b1;
        end
      end
    end
  end

  // One-entry response buffer and transmitter handshake FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_state     <= T_IDLE;
      buf_full    <= 1'b0;
      buf_data    <= 8'h0;
      tx_data     <= 8'h0;
      tx_send     <= 1'b0;
      overrun_cnt <= 8'h0;
    end else begin
      tx_send <= 1'b0;
      case (t_state)
        T_IDLE: begin
          if (deq) begin
            tx_data <= buf_data;
            tx_send <= 1'b1;
            t_state <= T_GUARD;
          end
        end
        T_GUARD: t_state <= T_BUSY;
        T_BUSY:  if (!tx_busy) t_state <= T_IDLE;
        default: t_state <= T_IDLE;
      endcase

      // Dequeue takes effect before a same-cycle enqueue.
      if (q_valid) begin
        if (!buf_full || deq) begin
          buf_full <= 1'b1;
          buf_data <= q_char;
        end else if (overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (deq) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule
